// File: rtl/multi_timer_pkg.sv
// multi_timer_pkg: register map, control/status bit positions and the
// per-channel run-state type shared by multi_timer and timer_channel.
package multi_timer_pkg;

  // Register offsets inside one channel's 8-entry window
  localparam logic [2:0] REG_STATUS   = 3'd0;
  localparam logic [2:0] REG_CONTROL  = 3'd1;
  localparam logic [2:0] REG_PERIOD_L = 3'd2;
  localparam logic [2:0] REG_PERIOD_H = 3'd3;
  localparam logic [2:0] REG_SNAP_L   = 3'd4;
  localparam logic [2:0] REG_SNAP_H   = 3'd5;
  localparam logic [2:0] REG_PRESCALE = 3'd6;
  localparam logic [2:0] REG_RESERVED = 3'd7;

  // Control register bit positions
  localparam int CTRL_ITO   = 0;
  localparam int CTRL_CONT  = 1;
  localparam int CTRL_START = 2;
  localparam int CTRL_STOP  = 3;

  // Status register bit positions
  localparam int STAT_TO  = 0;
  localparam int STAT_RUN = 1;

  // Channel run state; RUN in the status register is state == CH_RUNNING
  typedef enum logic {
    CH_STOPPED = 1'b0,
    CH_RUNNING = 1'b1
  } ch_state_e;

endpackage

// File: rtl/timer_channel.sv
// timer_channel: one down-counting timer (counter, RUN state, TO flag,
// period, snapshot). Optional prescaler compiled in by MULTI_TIMER_PRESCALE_EN.
module timer_channel
  import multi_timer_pkg::*;
#(
  parameter int CNT_W          = 32,
  parameter int DEFAULT_PERIOD = 49999
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             wr_en_i,      // write strobe already qualified for this channel
  input  logic [2:0]       wr_reg_i,
  input  logic [15:0]      wr_data_i,
  output ch_state_e        state_o,
  output logic             to_o,
  output logic [3:0]       ctrl_o,
  output logic [CNT_W-1:0] period_o,
  output logic [CNT_W-1:0] snap_o,
  output logic [15:0]      prescale_o,
  output logic             irq_o,
  output logic             timeout_o
);

  ch_state_e        state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] snap_q, snap_d;
  logic             to_q, to_d;
  logic [3:0]       ctrl_q, ctrl_d;
  logic             running, tick, timeout;
  logic             wr_status, wr_ctrl, wr_per_l, wr_per_h, wr_period, wr_snap;

  assign wr_status = wr_en_i && (wr_reg_i == REG_STATUS);
  assign wr_ctrl   = wr_en_i && (wr_reg_i == REG_CONTROL);
  assign wr_per_l  = wr_en_i && (wr_reg_i == REG_PERIOD_L);
  assign wr_per_h  = wr_en_i && (wr_reg_i == REG_PERIOD_H);
  assign wr_period = wr_per_l || wr_per_h;
  assign wr_snap   = wr_en_i && ((wr_reg_i == REG_SNAP_L) || (wr_reg_i == REG_SNAP_H));
  assign running   = (state_q == CH_RUNNING);
  assign timeout   = tick && (count_q == '0);

`ifdef MULTI_TIMER_PRESCALE_EN
  logic [15:0] psc_q, psc_d, psc_cnt_q, psc_cnt_d;
  logic        wr_psc, run_rise;

  assign wr_psc     = wr_en_i && (wr_reg_i == REG_PRESCALE);
  assign run_rise   = (state_d == CH_RUNNING) && (state_q == CH_STOPPED);
  assign tick       = running && (psc_cnt_q == psc_q);
  assign prescale_o = psc_q;

  // Prescaler: count 0..prescale, restart on RUN rising or prescale write
  always_comb begin
    psc_d     = psc_q;
    psc_cnt_d = psc_cnt_q;
    if (wr_psc) psc_d = wr_data_i;
    if (running) psc_cnt_d = tick ? 16'd0 : psc_cnt_q + 16'd1;
    if (run_rise || wr_psc) psc_cnt_d = 16'd0;
  end

  // Prescaler registers
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      psc_q     <= 16'd0;
      psc_cnt_q <= 16'd0;
    end else begin
      psc_q     <= psc_d;
      psc_cnt_q <= psc_cnt_d;
    end
  end
`else
  assign tick       = running;
  assign prescale_o = 16'd0;
`endif

  // Run-state next-state: STOP beats START, period write beats everything
  always_comb begin
    state_d = state_q;
    case (state_q)
      CH_STOPPED: begin
        if (wr_ctrl && wr_data_i[CTRL_START] && !wr_data_i[CTRL_STOP]) state_d = CH_RUNNING;
      end
      CH_RUNNING: begin
        if (timeout && !ctrl_q[CTRL_CONT]) state_d = CH_STOPPED;
        if (wr_ctrl && wr_data_i[CTRL_START]) state_d = CH_RUNNING;
        if (wr_ctrl && wr_data_i[CTRL_STOP]) state_d = CH_STOPPED;
      end
      default: state_d = CH_STOPPED;
    endcase
    if (wr_period) state_d = CH_STOPPED;
  end

  // Datapath next-state: counter, period halves, TO flag, control, snapshot
  always_comb begin
    period_d = period_q;
    count_d  = count_q;
    to_d     = to_q;
    ctrl_d   = ctrl_q;
    snap_d   = snap_q;
    if (wr_per_l) period_d[15:0] = wr_data_i;
    if (wr_per_h) period_d[CNT_W-1:16] = wr_data_i[CNT_W-17:0];
    if (tick) count_d = timeout ? period_q : count_q - CNT_W'(1);
    if (wr_period) count_d = period_d;
    if (wr_status) to_d = 1'b0;
    if (timeout) to_d = 1'b1;
    if (wr_ctrl) ctrl_d = wr_data_i[3:0];
    if (wr_snap) snap_d = count_q;
  end

  // Channel state registers
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= CH_STOPPED;
      count_q  <= CNT_W'(DEFAULT_PERIOD);
      period_q <= CNT_W'(DEFAULT_PERIOD);
      snap_q   <= '0;
      to_q     <= 1'b0;
      ctrl_q   <= 4'd0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      period_q <= period_d;
      snap_q   <= snap_d;
      to_q     <= to_d;
      ctrl_q   <= ctrl_d;
    end
  end

  assign state_o   = state_q;
  assign to_o      = to_q;
  assign ctrl_o    = ctrl_q;
  assign period_o  = period_q;
  assign snap_o    = snap_q;
  assign irq_o     = to_q && ctrl_q[CTRL_ITO];
  // A timeout in the reset cycle is abandoned, never shown
  assign timeout_o = timeout && !reset_i;

endmodule

// File: rtl/multi_timer.sv
// multi_timer: NUM_CH independent timers behind a 16-bit register port.
// Address is {channel, reg[2:0]}; readdata is registered one cycle after
// the address. Optional prescaler: define MULTI_TIMER_PRESCALE_EN.
// Bus: a write happens in any cycle with chipselect=1 and write_n=0; there
// is no wait state, and reads need no strobe (readdata tracks address).
module multi_timer
  import multi_timer_pkg::*;
#(
  parameter int NUM_CH         = 4,
  parameter int CNT_W          = 32,
  parameter int DEFAULT_PERIOD = 49999,
  localparam int AW            = $clog2(NUM_CH) + 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [AW-1:0]     address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [15:0]       writedata,
  output logic [15:0]       readdata,
  output logic              irq,
  output logic [NUM_CH-1:0] irq_vec,
  output logic [NUM_CH-1:0] timeout_pulse
);

  logic [AW-1:0]     ch_sel;
  logic              wr;
  logic [NUM_CH-1:0] wr_en;
  logic [NUM_CH-1:0] ch_to;
  ch_state_e         ch_state  [NUM_CH];
  logic [3:0]        ch_ctrl   [NUM_CH];
  logic [CNT_W-1:0]  ch_period [NUM_CH];
  logic [CNT_W-1:0]  ch_snap   [NUM_CH];
  logic [15:0]       ch_psc    [NUM_CH];
  logic [15:0]       rd_d, readdata_q;
  logic [31:0]       period_ext, snap_ext;

  assign ch_sel = address >> 3;
  assign wr     = chipselect && !write_n;

  // Write decode: out-of-range channels match no strobe
  always_comb begin
    wr_en = '0;
    for (int i = 0; i < NUM_CH; i++) wr_en[i] = wr && (ch_sel == AW'(i));
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    timer_channel #(
      .CNT_W          (CNT_W),
      .DEFAULT_PERIOD (DEFAULT_PERIOD)
    ) u_ch (
      .clk_i      (clk),
      .reset_i    (reset),
      .wr_en_i    (wr_en[g]),
      .wr_reg_i   (address[2:0]),
      .wr_data_i  (writedata),
      .state_o    (ch_state[g]),
      .to_o       (ch_to[g]),
      .ctrl_o     (ch_ctrl[g]),
      .period_o   (ch_period[g]),
      .snap_o     (ch_snap[g]),
      .prescale_o (ch_psc[g]),
      .irq_o      (irq_vec[g]),
      .timeout_o  (timeout_pulse[g])
    );
  end

  // Read mux: reserved register and out-of-range channels return 0
  always_comb begin
    rd_d       = 16'd0;
    period_ext = '0;
    snap_ext   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_sel == AW'(i)) begin
        period_ext = 32'(ch_period[i]);
        snap_ext   = 32'(ch_snap[i]);
        case (address[2:0])
          REG_STATUS:   rd_d = {14'd0, ch_state[i] == CH_RUNNING, ch_to[i]};
          REG_CONTROL:  rd_d = {12'd0, ch_ctrl[i]};
          REG_PERIOD_L: rd_d = period_ext[15:0];
          REG_PERIOD_H: rd_d = period_ext[31:16];
          REG_SNAP_L:   rd_d = snap_ext[15:0];
          REG_SNAP_H:   rd_d = snap_ext[31:16];
          REG_PRESCALE: rd_d = ch_psc[i];
          REG_RESERVED: rd_d = 16'd0;
          default:      rd_d = 16'd0;
        endcase
      end
    end
  end

  // Registered read data, refreshed every cycle
  always_ff @(posedge clk) begin
    if (reset) readdata_q <= 16'd0;
    else       readdata_q <= rd_d;
  end

  assign readdata = readdata_q;
  assign irq      = |irq_vec;

endmodule

// File: doc/multi_timer.md
MULTI_TIMER -- requirements
Module: multi_timer

Interface
REQ-001 Parameter NUM_CH, default 4, number of independent timer channels (1..8).
REQ-002 Parameter CNT_W, default 32, counter and period width in bits (17..32).
REQ-003 Parameter DEFAULT_PERIOD, default 49999, reset value of every period register.
REQ-004 clk  input  1  sole clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 address  input  $clog2(NUM_CH)+3  {channel, reg[2:0]}; reg 0 status, 1 control, 2 period_l, 3 period_h, 4 snap_l, 5 snap_h, 6 prescale, 7 reserved.
REQ-007 chipselect  input  1  slave select.
REQ-008 write_n  input  1  active-low write strobe, qualified by chipselect.
REQ-009 writedata  input  16  write data.
REQ-010 readdata  output  16  registered read data.
REQ-011 irq  output  1  OR of irq_vec.
REQ-012 irq_vec  output  NUM_CH  per-channel TO AND ITO.
REQ-013 timeout_pulse  output  NUM_CH  one-cycle pulse per channel timeout.

Function
REQ-014 readdata SHALL present the register addressed in cycle N at cycle N+1, updated every cycle regardless of chipselect.
REQ-015 Status read SHALL return {14'b0, RUN, TO}; control read {12'b0, STOP, START, CONT, ITO} with START/STOP bits reading as last written.
REQ-016 Period and snapshot SHALL split into low 16 bits (reg 2/4) and high CNT_W-16 bits zero-extended (reg 3/5); reserved reg 7 and out-of-range channels SHALL read 0 and ignore writes.
REQ-017 Each channel SHALL decrement its counter by 1 on each tick while RUN=1; tick is every clk unless REQ-033 applies.
REQ-018 On a tick with counter==0 and RUN=1: counter reloads period, timeout_pulse asserts that same cycle for one cycle, TO sets next cycle.
REQ-019 On timeout with CONT=0, RUN SHALL clear; with CONT=1, RUN stays set.
REQ-020 Control write with writedata[2]=1 SHALL set RUN; writedata[3]=1 SHALL clear RUN; both set: STOP wins.
REQ-021 Any write to period_l or period_h SHALL update that half, clear RUN, and load the full new period into the counter the next cycle.
REQ-022 Any write to status SHALL clear TO; simultaneous timeout on same channel: TO set wins.
REQ-023 Period write coinciding with timeout on same channel: period write wins (stopped, new value loaded); timeout_pulse still fires.
REQ-024 Write to snap_l or snap_h SHALL capture the live counter into the snapshot register next cycle.
REQ-025 Period value 0 SHALL time out on every tick while running.
REQ-026 Channels SHALL be fully independent; a write touches only the addressed channel.

Reset
REQ-027 Reset SHALL set counter and period to DEFAULT_PERIOD, RUN=0, TO=0, control=0, snapshot=0, prescale=0.
REQ-028 Reset SHALL drive readdata=0, irq=0, irq_vec=0, timeout_pulse=0 in the following cycle.
REQ-029 Reset asserted mid-count SHALL abandon count and suppress any pending timeout_pulse.

Configuration
REQ-030 Macro MULTI_TIMER_PRESCALE_EN SHALL compile in per-channel 16-bit prescale register (reg 6).
REQ-031 With the macro: tick asserts once every prescale+1 clk cycles; prescaler counter resets to 0 on RUN rising and on prescale write.
REQ-032 Without the macro: reg 6 reads 0, writes ignored, no prescaler logic synthesized.
REQ-033 Tick source per REQ-017 SHALL be the prescaler output when the macro is defined.

Structure
REQ-034 Package multi_timer_pkg SHALL hold register offset constants, control/status bit positions, and the channel-state typedef.
REQ-035 Sub-module timer_channel SHALL implement one channel (counter, RUN, TO, period, snapshot, optional prescaler), instantiated NUM_CH times; top holds decode and read mux.

Verification
REQ-036 Ch0 period 4, control 0x7 (START|CONT|ITO) -> timeout_pulse[0] every 5 cycles, irq rises; status write clears TO and irq next cycle.
REQ-037 Ch2 period 2, control 0x4 (one-shot) -> exactly one timeout_pulse[2], RUN reads 0 afterward, counter holds 2.
REQ-038 Status write coincident with ch1 timeout -> TO reads 1 afterward.
REQ-039 Ch3 running, write period_l=100 mid-count -> RUN=0, snapshot write then snap_l read returns 100.
REQ-040 Macro defined, ch0 prescale 3, period 1 -> timeout every 8 clk; macro undefined -> reg 6 reads 0.
REQ-041 Reset asserted for 1 cycle while all channels run -> all outputs 0, period_l reads 49999.
